// File: rtl/ucsbece154b_victim_wb_cache.sv
// Fully associative, exclusive victim cache with write-back of dirty lines and true LRU.
// Optional hit/miss counters are enabled by defining VICTIM_WB_STATS_EN.
module ucsbece154b_victim_wb_cache #(
  parameter int ADDR_WIDTH = 56,
  parameter int LINE_WIDTH = 128,
  parameter int NR_ENTRIES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef VICTIM_WB_STATS_EN
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o,
`endif
  input  logic                  flush_i,
  output logic                  flush_done_o,
  input  logic                  lk_valid_i,
  output logic                  lk_ready_o,
  input  logic [ADDR_WIDTH-1:0] lk_addr_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_hit_o,
  output logic                  rsp_dirty_o,
  output logic [LINE_WIDTH-1:0] rsp_data_o,
  input  logic                  ins_valid_i,
  output logic                  ins_ready_o,
  input  logic [ADDR_WIDTH-1:0] ins_addr_i,
  input  logic [LINE_WIDTH-1:0] ins_data_i,
  input  logic                  ins_dirty_i,
  output logic                  ev_valid_o,
  input  logic                  ev_ready_i,
  output logic [ADDR_WIDTH-1:0] ev_addr_o,
  output logic [LINE_WIDTH-1:0] ev_data_o
);
  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
  localparam int TAG_SIZE     = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int IDX_W        = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

  typedef enum logic [1:0] {IDLE, EVICT, FLUSH} state_t;
  state_t state, state_next;

  logic [NR_ENTRIES-1:0] valid, dirty, lk_match, ins_match, fl_mask;
  logic [TAG_SIZE-1:0]   tags [NR_ENTRIES];
  logic [LINE_WIDTH-1:0] data [NR_ENTRIES];
  // age 0 is LRU, NR_ENTRIES-1 is MRU; ages always form a permutation
  logic [IDX_W-1:0]      age  [NR_ENTRIES];

  logic [TAG_SIZE-1:0]   lk_tag, ins_tag;
  logic [IDX_W-1:0]      lk_idx, ins_idx, free_idx, lru_idx, fl_idx, tgt;
  logic                  lk_hit, ins_hit, has_free, any_dirty, victim_dirty;
  logic                  lk_fire, ins_fire, ev_fire;
  logic [ADDR_WIDTH-1:0] ev_addr_reg;
  logic [LINE_WIDTH-1:0] ev_data_reg;
  logic                  unused_addr_bits;

  assign lk_tag  = lk_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign ins_tag = ins_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign unused_addr_bits = ^{lk_addr_i, ins_addr_i};

  generate
    for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_match
      assign lk_match[gi]  = valid[gi] && (tags[gi] == lk_tag);
      assign ins_match[gi] = valid[gi] && (tags[gi] == ins_tag);
    end
  endgenerate

  // Descending scan leaves the lowest qualifying index in each selector
  always_comb begin
    lk_idx   = '0;
    ins_idx  = '0;
    free_idx = '0;
    lru_idx  = '0;
    fl_idx   = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (lk_match[i])    lk_idx   = IDX_W'(i);
      if (ins_match[i])   ins_idx  = IDX_W'(i);
      if (!valid[i])      free_idx = IDX_W'(i);
      if (dirty[i])       fl_idx   = IDX_W'(i);
      if (age[i] == '0)   lru_idx  = IDX_W'(i);
    end
  end

  assign lk_hit       = |lk_match;
  assign ins_hit      = |ins_match;
  assign has_free     = ~&valid;
  assign any_dirty    = |dirty;
  assign tgt          = ins_hit ? ins_idx : (has_free ? free_idx : lru_idx);
  assign victim_dirty = !ins_hit && !has_free && dirty[lru_idx];
  assign lk_fire      = lk_valid_i && lk_ready_o;
  assign ins_fire     = ins_valid_i && ins_ready_o;
  assign ev_fire      = ev_valid_o && ev_ready_i;
  assign fl_mask      = ev_fire ? (NR_ENTRIES'(1) << fl_idx) : '0;

  always_comb begin
    state_next   = state;
    lk_ready_o   = 1'b0;
    ins_ready_o  = 1'b0;
    ev_valid_o   = 1'b0;
    ev_addr_o    = '0;
    ev_data_o    = '0;
    flush_done_o = 1'b0;
    case (state)
      IDLE: begin
        lk_ready_o  = !rst_i && !flush_i;
        ins_ready_o = !rst_i && !flush_i && !lk_valid_i;
        if (flush_i)                        state_next = FLUSH;
        else if (ins_fire && victim_dirty)  state_next = EVICT;
      end
      EVICT: begin
        ev_valid_o = 1'b1;
        ev_addr_o  = ev_addr_reg;
        ev_data_o  = ev_data_reg;
        if (ev_ready_i) state_next = IDLE;
      end
      FLUSH: begin
        ev_valid_o   = any_dirty;
        ev_addr_o    = any_dirty ? ADDR_WIDTH'(tags[fl_idx]) << OFFSET_WIDTH : '0;
        ev_data_o    = any_dirty ? data[fl_idx] : '0;
        flush_done_o = !any_dirty;
        if (!any_dirty) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_hit_o   <= 1'b0;
      rsp_dirty_o <= 1'b0;
      rsp_data_o  <= '0;
      ev_addr_reg <= '0;
      ev_data_reg <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
        age[i]  <= IDX_W'(i);
      end
    end else begin
      state       <= state_next;
      rsp_valid_o <= lk_fire;
      rsp_hit_o   <= lk_fire && lk_hit;
      rsp_dirty_o <= lk_fire && lk_hit && dirty[lk_idx];
      rsp_data_o  <= (lk_fire && lk_hit) ? data[lk_idx] : '0;

      // Exclusive: a hit line leaves the cache and becomes the LRU slot
      if (lk_fire && lk_hit) begin
        valid[lk_idx] <= 1'b0;
        dirty[lk_idx] <= 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
          if (IDX_W'(i) == lk_idx)        age[i] <= '0;
          else if (age[i] < age[lk_idx])  age[i] <= age[i] + 1'b1;
        end
      end

      if (ins_fire) begin
        if (victim_dirty) begin
          ev_addr_reg <= ADDR_WIDTH'(tags[tgt]) << OFFSET_WIDTH;
          ev_data_reg <= data[tgt];
        end
        valid[tgt] <= 1'b1;
        dirty[tgt] <= ins_dirty_i || (ins_hit && dirty[tgt]);
        tags[tgt]  <= ins_tag;
        data[tgt]  <= ins_data_i;
        for (int i = 0; i < NR_ENTRIES; i++) begin
          if (IDX_W'(i) == tgt)        age[i] <= IDX_W'(NR_ENTRIES - 1);
          else if (age[i] > age[tgt])  age[i] <= age[i] - 1'b1;
        end
      end

      // Clean lines drop immediately; dirty ones drop as they are written back
      if (state == FLUSH) begin
        valid <= valid & dirty & ~fl_mask;
        dirty <= dirty & ~fl_mask;
        if (!any_dirty) begin
          for (int i = 0; i < NR_ENTRIES; i++) age[i] <= IDX_W'(i);
        end
      end
    end
  end

`ifdef VICTIM_WB_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (lk_fire) begin
      if (lk_hit && hit_cnt_o != '1)    hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (!lk_hit && miss_cnt_o != '1)  miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ucsbece154b_victim_wb_cache.sv
// Directed self-checking bench for the victim write-back cache (4 entries, 128-bit lines).
module tb_ucsbece154b_victim_wb_cache;
  localparam int AW = 56;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          flush_done;
  logic          lk_valid = 1'b0, lk_ready;
  logic [AW-1:0] lk_addr = '0;
  logic          rsp_valid, rsp_hit, rsp_dirty;
  logic [LW-1:0] rsp_data;
  logic          ins_valid = 1'b0, ins_ready;
  logic [AW-1:0] ins_addr = '0;
  logic [LW-1:0] ins_data = '0;
  logic          ins_dirty = 1'b0;
  logic          ev_valid, ev_ready = 1'b0;
  logic [AW-1:0] ev_addr;
  logic [LW-1:0] ev_data;
`ifdef VICTIM_WB_STATS_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ucsbece154b_victim_wb_cache #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .NR_ENTRIES(4)) dut (
    .clk_i(clk), .rst_i(rst),
`ifdef VICTIM_WB_STATS_EN
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt),
`endif
    .flush_i(flush), .flush_done_o(flush_done),
    .lk_valid_i(lk_valid), .lk_ready_o(lk_ready), .lk_addr_i(lk_addr),
    .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_dirty_o(rsp_dirty), .rsp_data_o(rsp_data),
    .ins_valid_i(ins_valid), .ins_ready_o(ins_ready), .ins_addr_i(ins_addr),
    .ins_data_i(ins_data), .ins_dirty_i(ins_dirty),
    .ev_valid_o(ev_valid), .ev_ready_i(ev_ready), .ev_addr_o(ev_addr), .ev_data_o(ev_data)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; lk_valid = 1'b0; ins_valid = 1'b0; ev_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_insert(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic dt);
    int n;
    @(negedge clk);
    ins_addr = a; ins_data = d; ins_dirty = dt; ins_valid = 1'b1;
    #1;
    n = 0;
    while (!ins_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!ins_ready) begin
      n_checks++; n_fail++;
      $display("FAIL insert_timeout addr=%h ins_ready=%b required 1", a, ins_ready);
    end
    @(posedge clk); #1;
    ins_valid = 1'b0;
    $display("insert addr=%h data=%h dirty=%b", a, d, dt);
  endtask

  task automatic do_lookup(input logic [AW-1:0] a, output logic v, output logic h,
                           output logic dt, output logic [LW-1:0] d);
    int n;
    @(negedge clk);
    lk_addr = a; lk_valid = 1'b1;
    #1;
    n = 0;
    while (!lk_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!lk_ready) begin
      n_checks++; n_fail++;
      $display("FAIL lookup_timeout addr=%h lk_ready=%b required 1", a, lk_ready);
    end
    @(posedge clk); #1;
    lk_valid = 1'b0;
    @(negedge clk);
    v = rsp_valid; h = rsp_hit; dt = rsp_dirty; d = rsp_data;
    $display("lookup addr=%h valid=%b hit=%b dirty=%b data=%h", a, v, h, dt, d);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({lk_ready, ins_ready, ev_valid, rsp_valid, flush_done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b required 00000",
               {lk_ready, ins_ready, ev_valid, rsp_valid, flush_done});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({lk_ready, ins_ready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_release_ready got=%b required 11", {lk_ready, ins_ready});
    end
  endtask

  task automatic test_lookup_hit();
    logic v, h, dt; logic [LW-1:0] d;
    apply_reset();
    do_insert(56'h100, 128'hA, 1'b0);
    do_insert(56'h200, 128'hB, 1'b0);
    do_insert(56'h300, 128'hC, 1'b0);
    do_lookup(56'h208, v, h, dt, d);
    n_checks++;
    if ({v, h, dt} !== 3'b110 || d !== 128'hB) begin
      n_fail++; $display("FAIL lookup_hit v/h/d=%b data=%h required 110 data=b", {v, h, dt}, d);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rsp_one_cycle rsp_valid=%b required 0", rsp_valid);
    end
    do_lookup(56'h208, v, h, dt, d);
    n_checks++;
    if ({v, h} !== 2'b10 || d !== '0) begin
      n_fail++; $display("FAIL lookup_exclusive v/h=%b data=%h required 10 data=0", {v, h}, d);
    end
  endtask

  task automatic test_evict();
    logic v, h, dt; logic [LW-1:0] d;
    apply_reset();
    do_insert(56'h100, 128'h1, 1'b1);
    do_insert(56'h200, 128'h2, 1'b0);
    do_insert(56'h300, 128'h3, 1'b0);
    do_insert(56'h400, 128'h4, 1'b0);
    do_insert(56'h500, 128'h5, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({ev_valid, lk_ready, ins_ready} !== 3'b100 || ev_addr !== 56'h100 || ev_data !== 128'h1) begin
      n_fail++;
      $display("FAIL evict_start v/lk/ins=%b addr=%h data=%h required 100 addr=100 data=1",
               {ev_valid, lk_ready, ins_ready}, ev_addr, ev_data);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (ev_valid !== 1'b1 || ev_addr !== 56'h100 || ev_data !== 128'h1) begin
      n_fail++; $display("FAIL evict_hold valid=%b addr=%h required 1 addr=100", ev_valid, ev_addr);
    end
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    n_checks++;
    if ({ev_valid, lk_ready} !== 2'b01) begin
      n_fail++; $display("FAIL evict_done v/lk=%b required 01", {ev_valid, lk_ready});
    end
    do_lookup(56'h500, v, h, dt, d);
    n_checks++;
    if (h !== 1'b1 || d !== 128'h5) begin
      n_fail++; $display("FAIL evict_new_line hit=%b data=%h required 1 data=5", h, d);
    end
    do_lookup(56'h100, v, h, dt, d);
    n_checks++;
    if (h !== 1'b0) begin
      n_fail++; $display("FAIL evict_victim_gone hit=%b required 0", h);
    end
  endtask

  task automatic test_merge();
    logic v, h, dt; logic [LW-1:0] d;
    apply_reset();
    do_insert(56'h100, 128'h1, 1'b0);
    do_insert(56'h100, 128'h2, 1'b1);
    do_lookup(56'h100, v, h, dt, d);
    n_checks++;
    if ({h, dt} !== 2'b11 || d !== 128'h2) begin
      n_fail++; $display("FAIL merge_dirty h/d=%b data=%h required 11 data=2", {h, dt}, d);
    end
    do_lookup(56'h100, v, h, dt, d);
    n_checks++;
    if (h !== 1'b0) begin
      n_fail++; $display("FAIL merge_single_entry hit=%b required 0", h);
    end
    do_insert(56'h300, 128'h3, 1'b1);
    do_insert(56'h300, 128'h4, 1'b0);
    do_lookup(56'h300, v, h, dt, d);
    n_checks++;
    if ({h, dt} !== 2'b11 || d !== 128'h4) begin
      n_fail++; $display("FAIL merge_sticky_dirty h/d=%b data=%h required 11 data=4", {h, dt}, d);
    end
  endtask

  task automatic test_flush();
    logic v, h, dt; logic [LW-1:0] d;
    logic [AW-1:0] addrs [4];
    addrs[0] = 56'h100; addrs[1] = 56'h200; addrs[2] = 56'h300; addrs[3] = 56'h400;
    apply_reset();
    do_insert(56'h100, 128'h10, 1'b0);
    do_insert(56'h200, 128'h20, 1'b1);
    do_insert(56'h300, 128'h30, 1'b0);
    do_insert(56'h400, 128'h40, 1'b1);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ev_valid !== 1'b1 || ev_addr !== 56'h200 || ev_data !== 128'h20 || flush_done !== 1'b0) begin
      n_fail++; $display("FAIL flush_beat0 v=%b addr=%h data=%h required 1 addr=200 data=20",
                         ev_valid, ev_addr, ev_data);
    end
    ev_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ev_valid !== 1'b1 || ev_addr !== 56'h400 || ev_data !== 128'h40) begin
      n_fail++; $display("FAIL flush_beat1 v=%b addr=%h data=%h required 1 addr=400 data=40",
                         ev_valid, ev_addr, ev_data);
    end
    @(negedge clk);
    ev_ready = 1'b0;
    n_checks++;
    if ({ev_valid, flush_done} !== 2'b01) begin
      n_fail++; $display("FAIL flush_done v/done=%b required 01", {ev_valid, flush_done});
    end
    @(negedge clk);
    n_checks++;
    if ({flush_done, lk_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_done_pulse done/lk=%b required 01", {flush_done, lk_ready});
    end
    for (int i = 0; i < 4; i++) begin
      do_lookup(addrs[i], v, h, dt, d);
      n_checks++;
      if ({v, h} !== 2'b10) begin
        n_fail++; $display("FAIL flush_miss addr=%h v/h=%b required 10", addrs[i], {v, h});
      end
    end
    // flush of an empty cache finishes on its first FLUSH cycle
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ev_valid, flush_done} !== 2'b01) begin
      n_fail++; $display("FAIL flush_empty v/done=%b required 01", {ev_valid, flush_done});
    end
  endtask

  task automatic test_reset_mid_evict();
    logic v, h, dt; logic [LW-1:0] d;
    apply_reset();
    do_insert(56'h100, 128'h1, 1'b1);
    do_insert(56'h200, 128'h2, 1'b0);
    do_insert(56'h300, 128'h3, 1'b0);
    do_insert(56'h400, 128'h4, 1'b0);
    do_insert(56'h500, 128'h5, 1'b0);
    @(negedge clk);
    n_checks++;
    if (ev_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_evict_setup ev_valid=%b required 1", ev_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ev_valid !== 1'b0 || ev_addr !== '0 || lk_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_drop v=%b addr=%h lk=%b required 0 0 0", ev_valid, ev_addr, lk_ready);
    end
    @(negedge clk); rst = 1'b0;
    do_lookup(56'h500, v, h, dt, d);
    n_checks++;
    if ({v, h} !== 2'b10) begin
      n_fail++; $display("FAIL rst_line_gone v/h=%b required 10", {v, h});
    end
  endtask

  task automatic test_back_to_back();
    logic v, h, dt; logic [LW-1:0] d;
    apply_reset();
    do_insert(56'h100, 128'h7, 1'b0);
    @(negedge clk);
    lk_addr = 56'h100; lk_valid = 1'b1;
    ins_addr = 56'h600; ins_data = 128'h6; ins_dirty = 1'b0; ins_valid = 1'b1;
    #1;
    n_checks++;
    if ({lk_ready, ins_ready} !== 2'b10) begin
      n_fail++; $display("FAIL lookup_priority lk/ins=%b required 10", {lk_ready, ins_ready});
    end
    @(posedge clk); #1; lk_valid = 1'b0;
    @(posedge clk); #1; ins_valid = 1'b0;
    do_lookup(56'h600, v, h, dt, d);
    n_checks++;
    if (h !== 1'b1 || d !== 128'h6) begin
      n_fail++; $display("FAIL deferred_insert hit=%b data=%h required 1 data=6", h, d);
    end
  endtask

`ifdef VICTIM_WB_STATS_EN
  task automatic test_stats();
    logic v, h, dt; logic [LW-1:0] d;
    apply_reset();
    do_insert(56'h100, 128'h1, 1'b0);
    do_insert(56'h200, 128'h2, 1'b0);
    do_insert(56'h300, 128'h3, 1'b0);
    do_lookup(56'h100, v, h, dt, d);
    do_lookup(56'h200, v, h, dt, d);
    do_lookup(56'h300, v, h, dt, d);
    do_lookup(56'h100, v, h, dt, d);
    do_lookup(56'h900, v, h, dt, d);
    n_checks++;
    if (hit_cnt !== 32'd3 || miss_cnt !== 32'd2) begin
      n_fail++; $display("FAIL stats hit=%0d miss=%0d required 3 2", hit_cnt, miss_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lookup_hit();
    test_evict();
    test_merge();
    test_flush();
    test_reset_mid_evict();
    test_back_to_back();
`ifdef VICTIM_WB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_victim_wb_cache.md
UCSBECE154B_VICTIM_WB_CACHE -- requirements
Module: ucsbece154b_victim_wb_cache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 56, byte address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, line width in bits; power of two, at least 8.
REQ-003 SHALL have parameter NR_ENTRIES, default 4, entry count; any integer of 1 or more.
REQ-004 SHALL derive OFFSET_WIDTH = clog2(LINE_WIDTH/8) and TAG_SIZE = ADDR_WIDTH-OFFSET_WIDTH; tag = addr[ADDR_WIDTH-1:OFFSET_WIDTH].
REQ-005 SHALL have ports:
 clk_i  in  1  clock, rising edge
 rst_i  in  1  asynchronous active-high reset
 flush_i  in  1  request write-back-and-invalidate of all entries
 flush_done_o  out  1  one-cycle pulse, flush finished
 lk_valid_i / lk_ready_o  in/out  1  lookup handshake
 lk_addr_i  in  ADDR_WIDTH  lookup address
 rsp_valid_o  out  1  lookup response valid
 rsp_hit_o, rsp_dirty_o  out  1  hit flag, dirty flag of hit line
 rsp_data_o  out  LINE_WIDTH  hit line data
 ins_valid_i / ins_ready_o  in/out  1  insert handshake
 ins_addr_i  in  ADDR_WIDTH  inserted line address
 ins_data_i  in  LINE_WIDTH  inserted line data
 ins_dirty_i  in  1  inserted line dirty
 ev_valid_o / ev_ready_i  out/in  1  write-back handshake
 ev_addr_o  out  ADDR_WIDTH  write-back address; offset bits are zero
 ev_data_o  out  LINE_WIDTH  write-back data

Function
REQ-006 SHALL be fully associative, with true LRU order over all NR_ENTRIES for any size.
REQ-007 SHALL use FSM states IDLE, EVICT and FLUSH.
REQ-008 SHALL assert lk_ready_o only in IDLE with flush_i low.
REQ-009 SHALL assert ins_ready_o only in IDLE with flush_i low and lk_valid_i low, so lookup has priority.
REQ-010 SHALL, one cycle after an accepted lookup, assert rsp_valid_o for exactly one cycle. rsp_hit_o, rsp_data_o and rsp_dirty_o SHALL reflect the state before that cycle's update. On a miss, rsp_data_o is 0.
REQ-011 SHALL make the cache exclusive: on a lookup hit, the entry is invalidated and becomes the next replacement target.
REQ-012 SHALL, on an accepted insert whose tag matches a valid entry, overwrite that entry's data, set dirty to OR of old and new, and make it MRU.
REQ-013 SHALL, on an accepted insert with no tag match, fill the lowest-index invalid entry if one exists, else replace the LRU entry; the written entry becomes MRU.
REQ-014 SHALL overwrite a clean LRU victim silently. For a dirty victim it SHALL capture the victim address and data into the ev register, write the new line in the same cycle, and enter EVICT.
REQ-015 SHALL, in EVICT, hold ev_valid_o and a stable ev_addr_o/ev_data_o until ev_ready_i is high, then return to IDLE next cycle.
REQ-016 SHALL, on flush_i high in IDLE, enter FLUSH. In FLUSH it SHALL present dirty valid entries on ev in ascending index order, one per ev handshake. It SHALL invalidate each presented entry on handshake and invalidate all clean entries.
REQ-017 SHALL, when no dirty entries remain in FLUSH (including when none existed), pulse flush_done_o, reset LRU order and return to IDLE. flush_i outside IDLE is ignored.
REQ-018 SHALL keep ev_valid_o low in IDLE.
REQ-019 SHALL, with NR_ENTRIES=1, always replace entry 0 and need no LRU storage.

Reset
REQ-020 SHALL, on rst_i high at any time, immediately:
 - clear all valid and dirty bits
 - go to IDLE
 - drive every output to 0, dropping any pending eviction
 - set LRU order to entry 0 LRU ... entry NR_ENTRIES-1 MRU
REQ-021 SHALL resume normal operation on the first rising edge after rst_i deasserts.

Configuration
REQ-022 SHALL, with macro VICTIM_WB_STATS_EN defined, add outputs hit_cnt_o and miss_cnt_o, 32 bits each. They count accepted lookups by result, saturate at all-ones and reset to 0.
REQ-023 SHALL, without VICTIM_WB_STATS_EN, have neither the ports nor the counter logic.

Verification (NR_ENTRIES=4, LINE_WIDTH=128, OFFSET_WIDTH=4)
REQ-024 Insert clean 0x100, 0x200 and 0x300 (data 0xA, 0xB, 0xC), then look up 0x208 -> next cycle rsp_valid=1, hit=1, data=0xB, dirty=0; repeat lookup 0x208 -> hit=0.
REQ-025 Fill 0x100 dirty, then 0x200, 0x300 and 0x400 clean, then insert 0x500 with ev_ready_i low -> ev_valid=1, ev_addr=0x100, ready outputs low. Hold 3 cycles, then raise ev_ready_i -> IDLE; lookup 0x500 hits.
REQ-026 Insert 0x100 clean with data 0x1, then 0x100 dirty with data 0x2 -> single entry; lookup returns data=0x2, dirty=1.
REQ-027 Entries 1 and 3 dirty, then pulse flush_i -> two ev beats in index order, then flush_done_o pulse; all subsequent lookups miss.
REQ-028 rst_i asserted mid-EVICT -> ev_valid_o drops with no clock edge; after release, lookup of the prior line misses.
REQ-029 With VICTIM_WB_STATS_EN defined, 3 hits and 2 misses -> hit_cnt_o=3, miss_cnt_o=2.
